// File: rtl/johnson_seq_ctrl.sv
// Command-driven Johnson (twisted-ring) phase sequencer.
// Accepts "step N times, forward or reverse" commands over valid/ready and
// supports pause, abort and a legality-checked preset load while idle.
module johnson_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             cmd_dir,
    input  logic             pause,
    input  logic             abort,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_q,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   q_nxt;
    logic [CNT_W-1:0]   remaining, remaining_nxt;
    logic               dir, dir_nxt;
    logic               done_nxt;
    logic               aborted_nxt;
    logic               err_nxt;

    // A Johnson state has at most one 0/1 boundary between adjacent bits:
    // all-zero, all-one, or a run of ones anchored at either end.
    function automatic logic is_legal(input logic [WIDTH-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (v[i] != v[i+1]) n++;
        end
        return (n <= 1);
    endfunction

    // One twisted-ring step; reverse is the exact inverse of forward.
    function automatic logic [WIDTH-1:0] jstep(input logic [WIDTH-1:0] v,
                                               input logic             rev);
        if (rev) return {~v[0], v[WIDTH-1:1]};
        else     return {v[WIDTH-2:0], ~v[WIDTH-1]};
    endfunction

    // A load strobe takes priority over commands, so the handshake is withheld.
    assign cmd_ready = (state == IDLE) && !ld;
    assign busy      = (state == RUN);

    // Next-state, phase update and completion-pulse decode.
    always_comb begin
        state_nxt     = state;
        q_nxt         = q;
        remaining_nxt = remaining;
        dir_nxt       = dir;
        done_nxt      = 1'b0;
        aborted_nxt   = 1'b0;
        err_nxt       = err;
        case (state)
            IDLE: begin
                if (ld) begin
                    if (is_legal(ld_q)) begin
                        q_nxt = ld_q;
                    end else begin
                        q_nxt   = '0;
                        err_nxt = 1'b1;
                    end
                end else if (cmd_valid) begin
                    if (cmd_steps == '0) begin
                        // Zero-length run completes immediately without entering RUN.
                        done_nxt = 1'b1;
                    end else begin
                        dir_nxt       = cmd_dir;
                        remaining_nxt = cmd_steps;
                        state_nxt     = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt   = IDLE;
                    aborted_nxt = 1'b1;
                end else if (!pause) begin
                    q_nxt         = jstep(q, dir);
                    remaining_nxt = remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control and phase registers; reset wins over any run in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            q       <= '0;
            done    <= 1'b0;
            aborted <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            q       <= q_nxt;
            done    <= done_nxt;
            aborted <= aborted_nxt;
            err     <= err_nxt;
        end
    end

    // Run bookkeeping; only meaningful in RUN, so it needs no reset.
    always_ff @(posedge clk) begin
        remaining <= remaining_nxt;
        dir       <= dir_nxt;
    end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Scoreboard bench for johnson_seq_ctrl: expected q changes and completion
// pulses are queued by the stimulus and consumed by an independent monitor.
module tb_johnson_seq_ctrl;

    localparam int W = 4;
    localparam int C = 8;

    logic         clk = 1'b0;
    logic         rst, cmd_valid, cmd_dir, pause, abort, ld;
    logic [C-1:0] cmd_steps;
    logic [W-1:0] ld_q;
    logic         cmd_ready, busy, done, aborted, err;
    logic [W-1:0] q;

    johnson_seq_ctrl #(.WIDTH(W), .CNT_W(C)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .pause(pause), .abort(abort),
        .ld(ld), .ld_q(ld_q), .q(q), .busy(busy), .done(done),
        .aborted(aborted), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0]   qexp[$];   // expected sequence of q changes
    logic [W+1:0]   evexp[$];  // expected {done, aborted, q} at each pulse
    logic [W-1:0]   prev_q = '0;

    int   bcnt, ndone, nab;
    logic rdy_s, ev_s;

    // Monitor: compares every q change and every completion pulse.
    initial begin
        logic [W-1:0] e;
        logic [W+1:0] ev;
        forever begin
            @(negedge clk);
            if (q !== prev_q) begin
                checks++;
                if (qexp.size() == 0) begin
                    errors++;
                    $display("FAIL q_change unexpected got %b", q);
                end else begin
                    e = qexp.pop_front();
                    if (q !== e) begin
                        errors++;
                        $display("FAIL q_change got %b want %b", q, e);
                    end
                end
                prev_q = q;
            end
            if (done === 1'b1 || aborted === 1'b1) begin
                checks++;
                if (evexp.size() == 0) begin
                    errors++;
                    $display("FAIL pulse unexpected got done=%b aborted=%b q=%b", done, aborted, q);
                end else begin
                    ev = evexp.pop_front();
                    if ({done, aborted, q} !== ev) begin
                        errors++;
                        $display("FAIL pulse got %b want %b", {done, aborted, q}, ev);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, want);
        end
    endtask

    // One clock: sample at the falling edge, return just after the rising edge.
    task automatic cyc();
        @(negedge clk);
        if (busy) bcnt++;
        if (done) ndone++;
        if (aborted) nab++;
        if (done || aborted) ev_s = 1'b1;
        rdy_s = cmd_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [C-1:0] n, input logic d);
        logic ok;
        ok = 1'b0;
        cmd_valid = 1'b1;
        cmd_steps = n;
        cmd_dir   = d;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (rdy_s) begin
                ok = 1'b1;
                break;
            end
        end
        cmd_valid = 1'b0;
        chk("cmd_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_end();
        ev_s = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (ev_s) break;
            cyc();
        end
        chk("run_end_timeout", 32'(ev_s), 32'd1);
    endtask

    task automatic load(input logic [W-1:0] v);
        ld   = 1'b1;
        ld_q = v;
        cyc();
        ld   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_steps = '0;
        pause = 1'b0; abort = 1'b0; ld = 1'b0; ld_q = '0;
        bcnt = 0; ndone = 0; nab = 0; rdy_s = 1'b0; ev_s = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_flags", {29'd0, done, aborted, err}, 32'd0);

        // Reset held two cycles in the middle of a forward-6 run.
        qexp.push_back(4'b0001); qexp.push_back(4'b0011); qexp.push_back(4'b0111);
        qexp.push_back(4'b0000);
        ndone = 0; nab = 0;
        send(6, 1'b0);
        repeat (3) cyc();
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        chk("midrst_q", 32'(q), 32'h0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(cmd_ready), 32'd1);
        chk("midrst_err", 32'(err), 32'd0);
        repeat (2) cyc();
        chk("midrst_no_pulse", 32'(ndone + nab), 32'd0);

        // Forward 5 from 0000.
        qexp.push_back(4'b0001); qexp.push_back(4'b0011); qexp.push_back(4'b0111);
        qexp.push_back(4'b1111); qexp.push_back(4'b1110);
        evexp.push_back({2'b10, 4'b1110});
        bcnt = 0; ndone = 0;
        send(5, 1'b0);
        wait_end();
        chk("fwd5_busy", 32'(bcnt), 32'd5);
        chk("fwd5_done", 32'(ndone), 32'd1);

        // Reverse 3 from 0000, then forward 8 wraps back to 1110.
        qexp.push_back(4'b0000);
        load(4'b0000);
        qexp.push_back(4'b1000); qexp.push_back(4'b1100); qexp.push_back(4'b1110);
        evexp.push_back({2'b10, 4'b1110});
        bcnt = 0;
        send(3, 1'b1);
        wait_end();
        chk("rev3_busy", 32'(bcnt), 32'd3);
        qexp.push_back(4'b1100); qexp.push_back(4'b1000); qexp.push_back(4'b0000);
        qexp.push_back(4'b0001); qexp.push_back(4'b0011); qexp.push_back(4'b0111);
        qexp.push_back(4'b1111); qexp.push_back(4'b1110);
        evexp.push_back({2'b10, 4'b1110});
        bcnt = 0;
        send(8, 1'b0);
        wait_end();
        chk("wrap8_busy", 32'(bcnt), 32'd8);
        chk("wrap8_q", 32'(q), 32'hE);

        // Forward 6 with a two-cycle pause after the second step.
        qexp.push_back(4'b0000);
        load(4'b0000);
        qexp.push_back(4'b0001); qexp.push_back(4'b0011); qexp.push_back(4'b0111);
        qexp.push_back(4'b1111); qexp.push_back(4'b1110); qexp.push_back(4'b1100);
        evexp.push_back({2'b10, 4'b1100});
        bcnt = 0;
        send(6, 1'b0);
        repeat (2) cyc();
        pause = 1'b1;
        cyc();
        chk("pause_hold_q", 32'(q), 32'h3);
        cyc();
        pause = 1'b0;
        chk("pause_hold_q2", 32'(q), 32'h3);
        wait_end();
        chk("pause_busy", 32'(bcnt), 32'd8);

        // Abort after the second step of a new forward 6.
        qexp.push_back(4'b1000); qexp.push_back(4'b0000);
        evexp.push_back({2'b01, 4'b0000});
        bcnt = 0; ndone = 0; nab = 0;
        send(6, 1'b0);
        repeat (2) cyc();
        abort = 1'b1;
        wait_end();
        abort = 1'b0;
        chk("abort_pulse", 32'(nab), 32'd1);
        chk("abort_no_done", 32'(ndone), 32'd0);
        chk("abort_busy", 32'(bcnt), 32'd3);
        chk("abort_q", 32'(q), 32'h0);

        // Legal and illegal presets; sticky error.
        qexp.push_back(4'b0111);
        load(4'b0111);
        chk("ld_legal_q", 32'(q), 32'h7);
        chk("ld_legal_err", 32'(err), 32'd0);
        qexp.push_back(4'b0000);
        load(4'b0101);
        chk("ld_illegal_q", 32'(q), 32'h0);
        chk("ld_illegal_err", 32'(err), 32'd1);

        // Load and command together: command waits one cycle.
        qexp.push_back(4'b0011); qexp.push_back(4'b0111); qexp.push_back(4'b1111);
        evexp.push_back({2'b10, 4'b1111});
        ld = 1'b1; ld_q = 4'b0011;
        cmd_valid = 1'b1; cmd_steps = 8'd2; cmd_dir = 1'b0;
        bcnt = 0;
        cyc();
        chk("ld_blocks_ready", 32'(rdy_s), 32'd0);
        ld = 1'b0;
        cyc();
        chk("ld_then_ready", 32'(rdy_s), 32'd1);
        cmd_valid = 1'b0;
        wait_end();
        chk("ld_cmd_busy", 32'(bcnt), 32'd2);
        chk("err_sticky", 32'(err), 32'd1);

        // Zero-step command.
        evexp.push_back({2'b10, 4'b1111});
        bcnt = 0; ndone = 0;
        send(0, 1'b0);
        wait_end();
        chk("zero_busy", 32'(bcnt), 32'd0);
        chk("zero_done", 32'(ndone), 32'd1);
        chk("zero_q", 32'(q), 32'hF);

        // Back-to-back: second command accepted in the done cycle.
        qexp.push_back(4'b1110); qexp.push_back(4'b1100); qexp.push_back(4'b1110);
        evexp.push_back({2'b10, 4'b1100});
        evexp.push_back({2'b10, 4'b1110});
        bcnt = 0; ndone = 0;
        send(2, 1'b0);
        repeat (2) cyc();
        cmd_valid = 1'b1; cmd_steps = 8'd1; cmd_dir = 1'b1;
        cyc();
        cmd_valid = 1'b0;
        chk("b2b_ready_in_done", {30'd0, rdy_s, 1'(ndone == 1)}, 32'd3);
        wait_end();
        chk("b2b_busy", 32'(bcnt), 32'd3);
        chk("b2b_done", 32'(ndone), 32'd2);

        // Reset clears the sticky error.
        qexp.push_back(4'b0000);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_clears_err", 32'(err), 32'd0);
        chk("rst_clears_q", 32'(q), 32'h0);

        repeat (3) cyc();
        chk("queues_drained", 32'(qexp.size() + evexp.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
